bnn_conv_pool: RTL and testbench

- Parametrised successor to the fixed 14x14x8 / 4-filter second conv layer of the MNIST BNN.
- Computes a 3x3 binary XNOR-popcount convolution over an IN_H x IN_W x IN_CH bit-packed feature map for N_FILT filters.
- Applies a per-filter threshold (folded batch-norm), then a 2x2 max-pool (OR).
- Weights, thresholds and padding value are parameters. Operation is started by a start/busy/done handshake instead of a global state code.
- Sits between any two layers of the BNN pipeline; instantiated as layer 2 with defaults.

---
 rtl/bnn_pkg.sv | 31 +++
 rtl/bnn_xnor_popcount.sv | 32 +++
 rtl/bnn_conv_pool.sv | 229 ++++++++++++++++++++++
 tb/tb_bnn_conv_pool.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN layer blocks: FSM states, width helpers and
// flat bit-index helpers for packed feature maps, weights and outputs.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int popcnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pix_idx(input int r, input int c, input int ch, input int w, input int nch);
        return (r * w + c) * nch + ch;
    endfunction

    function automatic int w_idx(input int f, input int kr, input int kc, input int ch, input int nch);
        return f * 9 * nch + (kr * 3 + kc) * nch + ch;
    endfunction

    function automatic int out_idx(input int f, input int r, input int c, input int oh, input int ow);
        return f * oh * ow + r * ow + c;
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational 3x3 x IN_CH XNOR match count: per-tap channel counts, then a
// sum across the nine taps.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int IN_CH = 8,
    parameter int CW    = popcnt_width(9 * IN_CH)
) (
    input  logic [9*IN_CH-1:0] win_i,
    input  logic [9*IN_CH-1:0] wgt_i,
    output logic [CW-1:0]      cnt_o
);

    localparam int TW = popcnt_width(IN_CH);

    logic [9*IN_CH-1:0] match_s;
    logic [TW-1:0]      tap_cnt_s [9];

    // XNOR matches, per-tap channel counts, then tap-level sum
    always_comb begin
        match_s = ~(win_i ^ wgt_i);
        cnt_o   = {CW{1'b0}};
        for (int t = 0; t < 9; t++) begin
            tap_cnt_s[t] = {TW{1'b0}};
            for (int ch = 0; ch < IN_CH; ch++) begin
                tap_cnt_s[t] = tap_cnt_s[t] + TW'(match_s[t*IN_CH+ch]);
            end
            cnt_o = cnt_o + CW'(tap_cnt_s[t]);
        end
    end

endmodule

// File: rtl/bnn_conv_pool.sv
// 3x3 binary conv + per-filter threshold + 2x2 OR max-pool, one conv per cycle.
// Optional macro BNN_CONV_PIPE_EN adds a register between compare and pool.
module bnn_conv_pool
    import bnn_pkg::*;
#(
    parameter int                       IN_H    = 14,
    parameter int                       IN_W    = 14,
    parameter int                       IN_CH   = 8,
    parameter int                       N_FILT  = 4,
    parameter logic                     PAD_VAL = 1'b0,
    parameter int                       CW      = popcnt_width(9 * IN_CH),
    parameter logic [N_FILT*9*IN_CH-1:0] WEIGHTS = '0,
    parameter logic [N_FILT*CW-1:0]     THRESH  = {7'd37, 7'd35, 7'd42, 7'd41}
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [IN_H*IN_W*IN_CH-1:0]           pixels,
    output logic                                 busy,
    output logic                                 done,
    output logic [N_FILT*(IN_H/2)*(IN_W/2)-1:0]  layer_out
);

    localparam int OH    = IN_H / 2;
    localparam int OW    = IN_W / 2;
    localparam int TAPS  = 9 * IN_CH;
    localparam int OUT_W = N_FILT * OH * OW;
    localparam int FW    = idx_width(N_FILT);
    localparam int RW    = idx_width(OH);
    localparam int CLW   = idx_width(OW);
    localparam int PIW   = idx_width(IN_H * IN_W * IN_CH);
    localparam int OIW   = idx_width(OUT_W);
    localparam int WIW   = idx_width(N_FILT * TAPS);
    localparam int TIW   = idx_width(N_FILT * CW);

    state_e             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [OUT_W-1:0]   layer_out_q, layer_out_d;
    logic [FW-1:0]      filt_q, filt_d;
    logic [RW-1:0]      orow_q, orow_d;
    logic [CLW-1:0]     ocol_q, ocol_d;
    logic [1:0]         pool_cnt_q, pool_cnt_d;
    logic               acc_q, acc_d;

    logic [TAPS-1:0]    win_s, wgt_s;
    logic [CW-1:0]      cnt_s, thr_s;
    logic               bit_s, last_s, adv_s;
    logic [OIW-1:0]     oidx_s;
    logic               wr_vld_s, wr_bit_s, wr_last_s;
    logic [1:0]         wr_pcnt_s;
    logic [OIW-1:0]     wr_oidx_s;

    // Gather the 3x3 window around the current conv centre, padding off-map taps
    always_comb begin
        win_s = {TAPS{1'b0}};
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                int rr;
                int cc;
                rr = int'(orow_q) * 2 + int'(pool_cnt_q[1]) + kr - 1;
                cc = int'(ocol_q) * 2 + int'(pool_cnt_q[0]) + kc - 1;
                if ((rr < 0) || (rr >= IN_H) || (cc < 0) || (cc >= IN_W)) begin
                    win_s[(kr*3+kc)*IN_CH +: IN_CH] = {IN_CH{PAD_VAL}};
                end else begin
                    win_s[(kr*3+kc)*IN_CH +: IN_CH] = pixels[PIW'(pix_idx(rr, cc, 0, IN_W, IN_CH)) +: IN_CH];
                end
            end
        end
    end

    assign wgt_s  = WEIGHTS[WIW'(int'(filt_q) * TAPS) +: TAPS];
    assign thr_s  = THRESH[TIW'(int'(filt_q) * CW) +: CW];
    assign bit_s  = (cnt_s > thr_s);
    assign oidx_s = OIW'(out_idx(int'(filt_q), int'(orow_q), int'(ocol_q), OH, OW));
    assign last_s = (filt_q == FW'(N_FILT - 1)) && (orow_q == RW'(OH - 1)) &&
                    (ocol_q == CLW'(OW - 1)) && (pool_cnt_q == 2'd3);

    bnn_xnor_popcount #(
        .IN_CH (IN_CH),
        .CW    (CW)
    ) u_pop (
        .win_i (win_s),
        .wgt_i (wgt_s),
        .cnt_o (cnt_s)
    );

`ifdef BNN_CONV_PIPE_EN
    logic           wr_vld_q, wr_bit_q, wr_last_q, drain_q, drain_d;
    logic [1:0]     wr_pcnt_q;
    logic [OIW-1:0] wr_oidx_q;

    // Address stops after the last conv; the drain cycle only retires the stage
    always_comb begin
        adv_s = (state_q == ST_RUN) && !drain_q;
        if (state_q != ST_RUN) begin
            drain_d = 1'b0;
        end else if (adv_s && last_s) begin
            drain_d = 1'b1;
        end else begin
            drain_d = drain_q;
        end
    end

    // Compare-to-pool pipeline stage
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_q  <= 1'b0;
            wr_bit_q  <= 1'b0;
            wr_last_q <= 1'b0;
            wr_pcnt_q <= 2'd0;
            wr_oidx_q <= {OIW{1'b0}};
            drain_q   <= 1'b0;
        end else begin
            wr_vld_q  <= adv_s;
            wr_bit_q  <= bit_s;
            wr_last_q <= last_s;
            wr_pcnt_q <= pool_cnt_q;
            wr_oidx_q <= oidx_s;
            drain_q   <= drain_d;
        end
    end

    assign wr_vld_s  = wr_vld_q;
    assign wr_bit_s  = wr_bit_q;
    assign wr_last_s = wr_last_q;
    assign wr_pcnt_s = wr_pcnt_q;
    assign wr_oidx_s = wr_oidx_q;
`else
    assign adv_s     = (state_q == ST_RUN);
    assign wr_vld_s  = adv_s;
    assign wr_bit_s  = bit_s;
    assign wr_last_s = last_s;
    assign wr_pcnt_s = pool_cnt_q;
    assign wr_oidx_s = oidx_s;
`endif

    // Next-state: FSM, conv address walk and pool accumulate/write-back
    always_comb begin
        state_d     = state_q;
        filt_d      = filt_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        pool_cnt_d  = pool_cnt_q;
        acc_d       = acc_q;
        layer_out_d = layer_out_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    filt_d     = {FW{1'b0}};
                    orow_d     = {RW{1'b0}};
                    ocol_d     = {CLW{1'b0}};
                    pool_cnt_d = 2'd0;
                    acc_d      = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (adv_s) begin
                    pool_cnt_d = pool_cnt_q + 2'd1;
                    if (pool_cnt_q == 2'd3) begin
                        if (ocol_q == CLW'(OW - 1)) begin
                            ocol_d = {CLW{1'b0}};
                            if (orow_q == RW'(OH - 1)) begin
                                orow_d = {RW{1'b0}};
                                filt_d = (filt_q == FW'(N_FILT - 1)) ? {FW{1'b0}} : filt_q + FW'(1);
                            end else begin
                                orow_d = orow_q + RW'(1);
                            end
                        end else begin
                            ocol_d = ocol_q + CLW'(1);
                        end
                    end else begin
                        ocol_d = ocol_q;
                    end
                end else begin
                    pool_cnt_d = pool_cnt_q;
                end
                if (wr_vld_s) begin
                    if (wr_pcnt_s == 2'd3) begin
                        layer_out_d[wr_oidx_s] = acc_q | wr_bit_s;
                        acc_d                  = 1'b0;
                    end else begin
                        acc_d = acc_q | wr_bit_s;
                    end
                    state_d = wr_last_s ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            layer_out_q <= {OUT_W{1'b0}};
            filt_q      <= {FW{1'b0}};
            orow_q      <= {RW{1'b0}};
            ocol_q      <= {CLW{1'b0}};
            pool_cnt_q  <= 2'd0;
            acc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            layer_out_q <= layer_out_d;
            filt_q      <= filt_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            pool_cnt_q  <= pool_cnt_d;
            acc_q       <= acc_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign layer_out = layer_out_q;

endmodule

// File: tb/tb_bnn_conv_pool.sv
// Randomized bench for bnn_conv_pool: four configurations checked against a
// loop-level reference model of conv / threshold / OR-pool.
module tb_bnn_conv_pool;

`ifdef BNN_CONV_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif
    localparam logic [71:0] W_D = 72'h9F3AC5E17B24D08E63;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    start, busy, done;
    logic [1567:0] pix_a, pix_b, pix_c;
    logic [255:0]  pix_d;
    logic [195:0]  out_a, out_b, out_c;
    logic [127:0]  out_d;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc;
    logic [255:0]  exp_v;

    always #5 clk = ~clk;

    bnn_conv_pool u_a (
        .clk(clk), .rst(rst), .start(start[0]), .pixels(pix_a),
        .busy(busy[0]), .done(done[0]), .layer_out(out_a)
    );
    bnn_conv_pool #(.THRESH({4{7'd39}})) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .pixels(pix_b),
        .busy(busy[1]), .done(done[1]), .layer_out(out_b)
    );
    bnn_conv_pool #(.PAD_VAL(1'b1), .THRESH({4{7'd39}})) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .pixels(pix_c),
        .busy(busy[2]), .done(done[2]), .layer_out(out_c)
    );
    bnn_conv_pool #(.IN_H(8), .IN_W(8), .IN_CH(4), .N_FILT(2), .WEIGHTS(W_D),
                    .THRESH({6'd20, 6'd18})) u_d (
        .clk(clk), .rst(rst), .start(start[3]), .pixels(pix_d),
        .busy(busy[3]), .done(done[3]), .layer_out(out_d)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Straight from the layer definition: count matching taps, threshold, OR over 2x2.
    function automatic logic [255:0] ref_model(input logic [2047:0] px, input logic [511:0] w,
                                               input int th[4], input int h, input int wd,
                                               input int ch, input int nf, input logic pad);
        logic [255:0] res;
        logic         p, any;
        int           oh, ow, cnt, pr, pc;
        res = '0;
        oh  = h / 2;
        ow  = wd / 2;
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < oh; r++)
                for (int c = 0; c < ow; c++) begin
                    any = 1'b0;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            cnt = 0;
                            for (int kr = 0; kr < 3; kr++)
                                for (int kc = 0; kc < 3; kc++)
                                    for (int k = 0; k < ch; k++) begin
                                        pr = 2 * r + dr + kr - 1;
                                        pc = 2 * c + dc + kc - 1;
                                        if (pr < 0 || pr >= h || pc < 0 || pc >= wd) p = pad;
                                        else p = px[(pr * wd + pc) * ch + k];
                                        if (p == w[f * 9 * ch + (kr * 3 + kc) * ch + k]) cnt++;
                                    end
                            if (cnt > th[f]) any = 1'b1;
                        end
                    res[f * oh * ow + r * ow + c] = any;
                end
        return res;
    endfunction

    // Start a pass on instance id; optionally pulse start or assert reset mid-run.
    task automatic run_pass(input int id, input int pulse_at, input int abort_at, output int cycles);
        int n;
        @(negedge clk);
        start[id] = 1'b1;
        @(posedge clk);
        #1;
        start[id] = 1'b0;
        chk("busy_after_start", 256'(busy[id]), 256'd1);
        chk("done_after_start", 256'(done[id]), 256'd0);
        for (n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            start[id] = (n == pulse_at);
            if (n == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                break;
            end
            if (done[id]) break;
        end
        cycles = n;
        if (abort_at < 0) begin
            chk("busy_at_done", 256'(busy[id]), 256'd0);
            chk("done_level", 256'(done[id]), 256'd1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 4'd0;
        pix_a = '0;
        pix_b = '0;
        pix_c = '0;
        pix_d = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_out_a", 256'(out_a), 256'd0);
        chk("rst_out_d", 256'(out_d), 256'd0);
        repeat (100) @(posedge clk);
        #1;
        chk("idle_busy", 256'(busy), 256'd0);
        chk("idle_done", 256'(done), 256'd0);
        chk("idle_out_a", 256'(out_a), 256'd0);

        // zero pixels and zero weights: every tap matches
        run_pass(0, -1, -1, cyc);
        chk("lat_zero", 256'(cyc), 256'(784 + PIPE));
        chk("out_zero", 256'(out_a), 256'({196{1'b1}}));

        // random pixels, default thresholds, ignored start pulse, restart from DONE
        for (int i = 0; i < 1568; i++) pix_a[i] = 1'($urandom_range(0, 1));
        run_pass(0, 10, -1, cyc);
        chk("lat_pulse", 256'(cyc), 256'(784 + PIPE));
        chk("out_rand_a", 256'(out_a), ref_model(2048'(pix_a), 512'(0), '{41, 42, 35, 37}, 14, 14, 8, 4, 1'b0));

        // all-ones image, threshold 39: only the four image-corner pool cells fire
        pix_b = '1;
        run_pass(1, -1, -1, cyc);
        chk("lat_b", 256'(cyc), 256'(784 + PIPE));
        exp_v = '0;
        for (int f = 0; f < 4; f++) begin
            exp_v[f * 49 + 0]  = 1'b1;
            exp_v[f * 49 + 6]  = 1'b1;
            exp_v[f * 49 + 42] = 1'b1;
            exp_v[f * 49 + 48] = 1'b1;
        end
        chk("out_corners", 256'(out_b), exp_v);
        chk("out_corners_model", 256'(out_b), ref_model(2048'(pix_b), 512'(0), '{39, 39, 39, 39}, 14, 14, 8, 4, 1'b0));

        pix_c = '1;
        run_pass(2, -1, -1, cyc);
        chk("lat_c", 256'(cyc), 256'(784 + PIPE));
        chk("out_pad1", 256'(out_c), 256'd0);

        // small configuration, two random passes
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 256; i++) pix_d[i] = 1'($urandom_range(0, 1));
            run_pass(3, -1, -1, cyc);
            chk("lat_d", 256'(cyc), 256'(128 + PIPE));
            chk("out_d", 256'(out_d), ref_model(2048'(pix_d), 512'(W_D), '{18, 20, 0, 0}, 8, 8, 4, 2, 1'b0));
        end

        // reset in the middle of a pass, then a clean pass
        for (int i = 0; i < 1568; i++) pix_a[i] = 1'($urandom_range(0, 1));
        run_pass(0, -1, 300, cyc);
        chk("abort_out", 256'(out_a), 256'd0);
        chk("abort_busy", 256'(busy[0]), 256'd0);
        chk("abort_done", 256'(done[0]), 256'd0);
        run_pass(0, -1, -1, cyc);
        chk("lat_after_abort", 256'(cyc), 256'(784 + PIPE));
        chk("out_after_abort", 256'(out_a), ref_model(2048'(pix_a), 512'(0), '{41, 42, 35, 37}, 14, 14, 8, 4, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
